// File: rtl/fetch_stage_if.sv
// Instruction-memory read handshake between the fetch stage (master) and imem (slave).
// addr is held while req is high; ack is a one-cycle completion pulse carrying rdata.
interface fetch_stage_if #(
   parameter int ADDR_W = 16
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       rdata;
   logic              ack;

   modport master (output req, output addr, input rdata, input ack);
   modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake and loads IF/ID.
// A one-entry skid buffer absorbs stalls; redirect/HALT on an in-flight request park in DROP.
module fetch_stage #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_stage_if.master     imem,
   input  logic              i_stall_in,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   input  logic              i_halt,
   output logic              o_ifid_valid,
   output logic [15:0]       o_ifid_instr,
   output logic [ADDR_W-1:0] o_ifid_pc2,
   output logic              o_halted
);

   // state    | meaning
   // ST_FETCH | normal fetch; request whenever the skid buffer is empty
   // ST_DROP  | in-flight data is discarded on ack; then r_drop_pc or HALT
   // ST_HALT  | fetch stopped; left only through reset
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_DROP  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_run;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_drop_pc;
   logic              r_drop_halt;
   logic              r_buf_valid;
   logic [15:0]       r_buf_instr;
   logic [ADDR_W-1:0] r_buf_pc2;
   logic              r_ifid_valid;
   logic [15:0]       r_ifid_instr;
   logic [ADDR_W-1:0] r_ifid_pc2;

   state_t            w_nxt_state;
   logic [ADDR_W-1:0] w_nxt_pc;
   logic [ADDR_W-1:0] w_nxt_drop_pc;
   logic              w_nxt_drop_halt;
   logic              w_nxt_buf_valid;
   logic [15:0]       w_nxt_buf_instr;
   logic [ADDR_W-1:0] w_nxt_buf_pc2;
   logic              w_nxt_ifid_valid;
   logic [15:0]       w_nxt_ifid_instr;
   logic [ADDR_W-1:0] w_nxt_ifid_pc2;

   logic              w_req;
   logic              w_ack;
   logic [ADDR_W-1:0] w_pc2;

   // r_run keeps the request low during reset and for the first edge after release
   assign w_req = r_run && (((r_state == ST_FETCH) && !r_buf_valid) || (r_state == ST_DROP));
   assign w_ack = imem.ack && w_req;
   assign w_pc2 = r_pc + ADDR_W'(2);

   assign imem.req     = w_req;
   assign imem.addr    = r_pc;
   assign o_ifid_valid = r_ifid_valid;
   assign o_ifid_instr = r_ifid_instr;
   assign o_ifid_pc2   = r_ifid_pc2;
   assign o_halted     = (r_state == ST_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_FETCH;
         r_run        <= 1'b0;
         r_pc         <= RESET_PC;
         r_drop_pc    <= '0;
         r_drop_halt  <= 1'b0;
         r_buf_valid  <= 1'b0;
         r_buf_instr  <= '0;
         r_buf_pc2    <= '0;
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= '0;
         r_ifid_pc2   <= '0;
      end else begin
         r_state      <= w_nxt_state;
         r_run        <= 1'b1;
         r_pc         <= w_nxt_pc;
         r_drop_pc    <= w_nxt_drop_pc;
         r_drop_halt  <= w_nxt_drop_halt;
         r_buf_valid  <= w_nxt_buf_valid;
         r_buf_instr  <= w_nxt_buf_instr;
         r_buf_pc2    <= w_nxt_buf_pc2;
         r_ifid_valid <= w_nxt_ifid_valid;
         r_ifid_instr <= w_nxt_ifid_instr;
         r_ifid_pc2   <= w_nxt_ifid_pc2;
      end
   end

   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_pc         = r_pc;
      w_nxt_drop_pc    = r_drop_pc;
      w_nxt_drop_halt  = r_drop_halt;
      w_nxt_buf_valid  = r_buf_valid;
      w_nxt_buf_instr  = r_buf_instr;
      w_nxt_buf_pc2    = r_buf_pc2;
      w_nxt_ifid_valid = r_ifid_valid;
      w_nxt_ifid_instr = r_ifid_instr;
      w_nxt_ifid_pc2   = r_ifid_pc2;

      case (r_state)
         ST_HALT: begin
            if (!i_stall_in) begin
               w_nxt_ifid_valid = 1'b0;
            end
         end
         ST_FETCH, ST_DROP: begin
            if (i_redirect) begin
               w_nxt_ifid_valid = 1'b0;
               w_nxt_buf_valid  = 1'b0;
               if (w_req && !w_ack) begin
                  w_nxt_drop_pc   = i_redirect_pc;
                  w_nxt_drop_halt = 1'b0;
                  w_nxt_state     = ST_DROP;
               end else begin
                  w_nxt_pc    = i_redirect_pc;
                  w_nxt_state = ST_FETCH;
               end
            end else if (i_halt) begin
               // anything in the skid buffer is younger than the HALT and is dropped
               w_nxt_buf_valid = 1'b0;
               if (!i_stall_in) begin
                  w_nxt_ifid_valid = 1'b0;
               end
               if (w_req && !w_ack) begin
                  w_nxt_drop_halt = 1'b1;
                  w_nxt_state     = ST_DROP;
               end else begin
                  w_nxt_state = ST_HALT;
               end
            end else if (r_state == ST_DROP) begin
               if (!i_stall_in) begin
                  w_nxt_ifid_valid = 1'b0;
               end
               if (w_ack) begin
                  if (r_drop_halt) begin
                     w_nxt_state = ST_HALT;
                  end else begin
                     w_nxt_pc    = r_drop_pc;
                     w_nxt_state = ST_FETCH;
                  end
               end
            end else if (w_ack) begin
               w_nxt_pc = w_pc2;
               if (!i_stall_in) begin
                  w_nxt_ifid_valid = 1'b1;
                  w_nxt_ifid_instr = imem.rdata;
                  w_nxt_ifid_pc2   = w_pc2;
               end else begin
                  w_nxt_buf_valid = 1'b1;
                  w_nxt_buf_instr = imem.rdata;
                  w_nxt_buf_pc2   = w_pc2;
               end
            end else if (!i_stall_in) begin
               if (r_buf_valid) begin
                  w_nxt_ifid_valid = 1'b1;
                  w_nxt_ifid_instr = r_buf_instr;
                  w_nxt_ifid_pc2   = r_buf_pc2;
                  w_nxt_buf_valid  = 1'b0;
               end else begin
                  w_nxt_ifid_valid = 1'b0;
               end
            end
         end
         default: begin
            w_nxt_state = ST_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable imem model plus a scoreboard of
// expected IF/ID loads that is drained by a monitor whenever a fresh entry appears.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_in = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        halt = 1'b0;
   logic        ifid_valid;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc2;
   logic        halted;
   logic        stall_q = 1'b0;

   int n_err = 0;
   int n_chk = 0;
   int mem_lat = 1;
   int mem_cnt = 0;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc2;
   } exp_t;
   exp_t sb[$];

   fetch_stage_if #(.ADDR_W(16)) imem_bus ();

   fetch_stage #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem         (imem_bus),
      .i_stall_in   (stall_in),
      .i_redirect   (redirect),
      .i_redirect_pc(redirect_pc),
      .i_halt       (halt),
      .o_ifid_valid (ifid_valid),
      .o_ifid_instr (ifid_instr),
      .o_ifid_pc2   (ifid_pc2),
      .o_halted     (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: mem_word = 16'h1111;
         16'h0002: mem_word = 16'h2222;
         16'h0004: mem_word = 16'h3333;
         default:  mem_word = a ^ 16'hA5A5;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   16'(imem_bus.req), 16'h0000);
      chk({tag, "_addr"},  imem_bus.addr,     16'h0000);
      chk({tag, "_valid"}, 16'(ifid_valid),   16'h0000);
      chk({tag, "_instr"}, ifid_instr,        16'h0000);
      chk({tag, "_pc2"},   ifid_pc2,          16'h0000);
      chk({tag, "_halted"}, 16'(halted),      16'h0000);
   endtask

   // Memory acks mem_lat edges after the request is first sampled.
   initial begin
      imem_bus.ack   = 1'b0;
      imem_bus.rdata = 16'h0000;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            imem_bus.ack = 1'b0;
            mem_cnt = 0;
         end else if (imem_bus.ack) begin
            imem_bus.ack = 1'b0;
            mem_cnt = imem_bus.req ? 1 : 0;
         end else if (imem_bus.req) begin
            mem_cnt++;
            if (mem_cnt == mem_lat + 1) begin
               imem_bus.ack   = 1'b1;
               imem_bus.rdata = mem_word(imem_bus.addr);
            end
         end else begin
            mem_cnt = 0;
         end
      end
   end

   always @(posedge clk) stall_q <= stall_in;

   // Valid IF/ID after an unstalled edge is always a fresh load.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && ifid_valid && !stall_q) begin
            chk("sb_has_entry", 16'(sb.size() != 0), 16'h0001);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_instr", ifid_instr, e.instr);
               chk("sb_pc2",   ifid_pc2,   e.pc2);
            end
         end
      end
   end

   task automatic wait_ack_consumed(input string tag, input int max);
      logic got;
      got = 1'b0;
      for (int i = 0; i < max && !got; i++) begin
         @(posedge clk);
         #1;
         if (imem_bus.ack) got = 1'b1;
      end
      chk({tag, "_ack_seen"}, 16'(got), 16'h0001);
   endtask

   task automatic wait_ack_pending(input string tag, input int max);
      logic got;
      got = 1'b0;
      for (int i = 0; i < max && !got; i++) begin
         @(negedge clk);
         #1;
         if (imem_bus.ack) got = 1'b1;
      end
      chk({tag, "_ack_pending"}, 16'(got), 16'h0001);
   endtask

   task automatic wait_req(input string tag, input int max);
      logic got;
      got = 1'b0;
      for (int i = 0; i < max && !got; i++) begin
         @(posedge clk);
         #1;
         if (imem_bus.req) got = 1'b1;
      end
      chk({tag, "_req_seen"}, 16'(got), 16'h0001);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      #7;
      chk_reset_vals("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: back-to-back fetch from 0 with 1-cycle memory
      wait_req("t1", 5);
      chk("t1_addr0", imem_bus.addr, 16'h0000);
      sb.push_back('{instr: 16'h1111, pc2: 16'h0002});
      sb.push_back('{instr: 16'h2222, pc2: 16'h0004});
      wait_ack_consumed("t1_a0", 10);
      chk("t1_addr2", imem_bus.addr, 16'h0002);
      wait_ack_consumed("t1_a1", 10);
      stall_in = 1'b1;
      chk("t1_addr4", imem_bus.addr, 16'h0004);

      // 2: ack lands while stalled -> skid buffer, request drops, IF/ID frozen
      sb.push_back('{instr: 16'h3333, pc2: 16'h0006});
      wait_ack_consumed("t2", 10);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         chk("t2_req_low",   16'(imem_bus.req), 16'h0000);
         chk("t2_hold_inst", ifid_instr,        16'h2222);
         chk("t2_hold_pc2",  ifid_pc2,          16'h0004);
         chk("t2_hold_vld",  16'(ifid_valid),   16'h0001);
      end
      stall_in = 1'b0;
      mem_lat = 4;
      @(posedge clk);
      #1;
      chk("t2_resume_req",  16'(imem_bus.req), 16'h0001);
      chk("t2_resume_addr", imem_bus.addr,     16'h0006);

      // 3: redirect the cycle after req rises on a 4-cycle memory
      redirect = 1'b1;
      redirect_pc = 16'h0040;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      chk("t3_flush",     16'(ifid_valid), 16'h0000);
      chk("t3_addr_held", imem_bus.addr,   16'h0006);
      @(posedge clk);
      #1;
      chk("t3_addr_held2", imem_bus.addr,  16'h0006);
      wait_ack_consumed("t3", 10);
      chk("t3_new_addr", imem_bus.addr,     16'h0040);
      chk("t3_new_req",  16'(imem_bus.req), 16'h0001);
      chk("t3_valid",    16'(ifid_valid),   16'h0000);

      // 4: redirect coincident with ack
      wait_ack_pending("t4", 12);
      redirect = 1'b1;
      redirect_pc = 16'h0100;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      chk("t4_addr",  imem_bus.addr,   16'h0100);
      chk("t4_valid", 16'(ifid_valid), 16'h0000);

      // 5: halt with a 3-cycle request outstanding
      mem_lat = 3;
      halt = 1'b1;
      @(posedge clk);
      #1;
      halt = 1'b0;
      chk("t5_not_yet", 16'(halted),       16'h0000);
      chk("t5_req",     16'(imem_bus.req), 16'h0001);
      chk("t5_addr",    imem_bus.addr,     16'h0100);
      wait_ack_consumed("t5", 10);
      chk("t5_halted", 16'(halted),       16'h0001);
      chk("t5_no_req", 16'(imem_bus.req), 16'h0000);
      chk("t5_valid",  16'(ifid_valid),   16'h0000);
      redirect = 1'b1;
      redirect_pc = 16'h0200;
      halt = 1'b1;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      halt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t5_pc_kept",  imem_bus.addr,     16'h0100);
         chk("t5_req_idle", 16'(imem_bus.req), 16'h0000);
         chk("t5_still",    16'(halted),       16'h0001);
         @(posedge clk);
         #1;
      end

      // reset out of HALT is asynchronous
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_halt");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mem_lat = 1;

      // 6: reach 0xFFFE via a dropped request, then wrap
      wait_req("t6", 5);
      chk("t6_addr0", imem_bus.addr, 16'h0000);
      redirect = 1'b1;
      redirect_pc = 16'hFFFE;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      chk("t6_addr_held", imem_bus.addr, 16'h0000);
      sb.push_back('{instr: 16'h5A5B, pc2: 16'h0000});
      wait_ack_consumed("t6_drop", 10);
      chk("t6_addr_fffe", imem_bus.addr, 16'hFFFE);
      wait_ack_consumed("t6_top", 10);
      chk("t6_wrap_addr", imem_bus.addr, 16'h0000);
      sb.push_back('{instr: 16'h1111, pc2: 16'h0002});
      wait_ack_consumed("t6_zero", 10);
      chk("t6_addr2", imem_bus.addr,     16'h0002);
      chk("t6_req",   16'(imem_bus.req), 16'h0001);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_mid");
      chk("sb_drained", 16'(sb.size()), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
